// File: rtl/demux_stream_1xn.sv
// rtl/demux_stream_1xn.sv - one-word stream demultiplexer to 2**N channels with broadcast
module demux_stream_1xn #(
   parameter int N = 2,
   parameter int W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W-1:0]      in_data,
   input  logic [N-1:0]      in_sel,
   input  logic              in_bcast,
   output logic [2**N-1:0]   out_valid,
   input  logic [2**N-1:0]   out_ready,
   output logic [W-1:0]      out_data,
   output logic              busy,
   output logic [15:0]       xfer_cnt
);

   localparam int C = 2**N;

   typedef enum logic {IDLE, HOLD} state_t;

   state_t         state;
   state_t         state_nxt;
   logic [C-1:0]   pend;
   logic [C-1:0]   pend_nxt;
   logic [C-1:0]   stall;
   logic [W-1:0]   data_q;
   logic [W-1:0]   data_nxt;
   logic           accept;
   logic           last_done;

   // Next pending mask, data and state; a new word may load in the same
   // cycle the last pending channel completes, so no idle bubble appears.
   always_comb begin
      stall     = pend & ~out_ready;
      in_ready  = en & (stall == '0);
      accept    = in_valid & in_ready;
      last_done = (state == HOLD) && (stall == '0);
      pend_nxt  = stall;
      data_nxt  = data_q;
      if (accept) begin
         data_nxt = in_data;
         if (in_bcast) begin
            pend_nxt = '1;
         end else begin
            pend_nxt         = '0;
            pend_nxt[in_sel] = 1'b1;
         end
      end
      state_nxt = (pend_nxt != '0) ? HOLD : IDLE;
   end

   // State, held word and delivery counter; reset discards the held word at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pend     <= '0;
         data_q   <= '0;
         xfer_cnt <= '0;
      end else begin
         state  <= state_nxt;
         pend   <= pend_nxt;
         data_q <= data_nxt;
         if (last_done) begin
            xfer_cnt <= xfer_cnt + 16'd1;
         end
      end
   end

   assign out_valid = pend;
   assign out_data  = data_q;
   assign busy      = (state == HOLD);

endmodule

// File: tb/tb_demux_stream_1xn.sv
// tb/tb_demux_stream_1xn.sv - self-checking bench for demux_stream_1xn
module tb_demux_stream_1xn;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = 8'h00;
   logic [1:0]  in_sel = 2'd0;
   logic        in_bcast = 1'b0;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready = 4'hF;
   logic [7:0]  out_data;
   logic        busy;
   logic [15:0] xfer_cnt;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic [7:0] data;
      logic [3:0] rem;
   } sb_t;
   sb_t         sbq[$];
   logic [15:0] mcnt = 16'd0;

   typedef struct {
      logic [7:0] data;
      logic [1:0] sel;
      logic       bcast;
      logic [3:0] mask;
   } vec_t;
   vec_t vec[6];

   logic [15:0] base;
   int          nfill;

   demux_stream_1xn #(.N(2), .W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_bcast  (in_bcast),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .xfer_cnt  (xfer_cnt)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Hard stop if the run never reaches its summary
   initial begin
      #3000000;
      $display("FAIL watchdog: act=timeout req=finish");
      $fatal(1, "watchdog");
   end

   function automatic void check(string name, logic [31:0] act, logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: act=%0h req=%0h at %0t", name, act, req, $time);
      end
   endfunction

   // Reset empties the reference model immediately
   always @(negedge rst_n) begin
      sbq.delete();
      mcnt = 16'd0;
   end

   // Scoreboard: check outputs against the reference word, then retire
   // completed channels and push newly accepted words
   always @(negedge clk) begin
      if (rst_n) begin
         sb_t        h;
         logic [3:0] pnd;
         logic       rdy;
         pnd = (sbq.size() > 0) ? sbq[0].rem : 4'b0000;
         check("mon_valid", 32'(out_valid), 32'(pnd));
         check("mon_busy", 32'(busy), 32'(pnd != 4'b0000));
         check("mon_cnt", 32'(xfer_cnt), 32'(mcnt));
         if (sbq.size() > 0) check("mon_data", 32'(out_data), 32'(sbq[0].data));
         rdy = en && ((pnd & ~out_ready) == 4'b0000);
         check("mon_in_ready", 32'(in_ready), 32'(rdy));
         if (sbq.size() > 0) begin
            h = sbq.pop_front();
            h.rem = h.rem & ~out_ready;
            if (h.rem != 4'b0000) sbq.push_front(h);
            else mcnt = mcnt + 16'd1;
         end
         if (in_valid && rdy) begin
            h.data = in_data;
            h.rem  = in_bcast ? 4'hF : (4'b0001 << in_sel);
            sbq.push_back(h);
         end
      end
   end

   initial begin
      vec[0] = '{8'h11, 2'd0, 1'b0, 4'b0001};
      vec[1] = '{8'h22, 2'd1, 1'b0, 4'b0010};
      vec[2] = '{8'h33, 2'd3, 1'b0, 4'b1000};
      vec[3] = '{8'h44, 2'd2, 1'b1, 4'b1111};
      vec[4] = '{8'h55, 2'd2, 1'b0, 4'b0100};
      vec[5] = '{8'hFF, 2'd3, 1'b1, 4'b1111};

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_data", 32'(out_data), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_cnt", 32'(xfer_cnt), 32'h0);

      // Single word on sel 2, accepted on the first edge after reset release
      @(posedge clk); #1;
      rst_n = 1'b1; in_valid = 1'b1; in_data = 8'hA5; in_sel = 2'd2; in_bcast = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("single_valid", 32'(out_valid), 32'b0100);
      check("single_data", 32'(out_data), 32'hA5);
      check("single_busy", 32'(busy), 32'h1);
      @(posedge clk); #1;
      check("single_done", 32'(out_valid), 32'h0);
      check("single_cnt", 32'(xfer_cnt), 32'h1);

      // Broadcast with split readiness
      in_valid = 1'b1; in_data = 8'h3C; in_bcast = 1'b1; out_ready = 4'b0101;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bc_valid0", 32'(out_valid), 32'hF);
      check("bc_rdy0", 32'(in_ready), 32'h0);
      @(posedge clk); #1;
      out_ready = 4'b1010;
      #1;
      check("bc_valid1", 32'(out_valid), 32'b1010);
      check("bc_data1", 32'(out_data), 32'h3C);
      check("bc_rdy1", 32'(in_ready), 32'h1);
      @(posedge clk); #1;
      check("bc_valid2", 32'(out_valid), 32'h0);
      check("bc_cnt", 32'(xfer_cnt), 32'h2);
      in_bcast = 1'b0; out_ready = 4'hF;

      // Back-to-back words, one per cycle
      base = xfer_cnt;
      in_valid = 1'b1; in_data = 8'h01; in_sel = 2'd0;
      @(posedge clk); #1;
      in_data = 8'h02; in_sel = 2'd1;
      check("b2b_v0", 32'(out_valid), 32'b0001);
      check("b2b_d0", 32'(out_data), 32'h01);
      @(posedge clk); #1;
      in_data = 8'h03; in_sel = 2'd3;
      check("b2b_v1", 32'(out_valid), 32'b0010);
      check("b2b_d1", 32'(out_data), 32'h02);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("b2b_v2", 32'(out_valid), 32'b1000);
      check("b2b_d2", 32'(out_data), 32'h03);
      @(posedge clk); #1;
      check("b2b_cnt", 32'(xfer_cnt - base), 32'h3);

      // Vector table, one isolated word each
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_data = vec[i].data; in_sel = vec[i].sel; in_bcast = vec[i].bcast;
         @(posedge clk); #1;
         in_valid = 1'b0; in_data = ~vec[i].data;
         check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vec[i].mask));
         check($sformatf("vec%0d_data", i), 32'(out_data), 32'(vec[i].data));
         @(posedge clk); #1;
         check($sformatf("vec%0d_idle", i), 32'(out_valid), 32'h0);
      end
      in_bcast = 1'b0;

      // Stalled channel with en and inputs toggling
      in_valid = 1'b1; in_data = 8'h77; in_sel = 2'd1; out_ready = 4'b1101;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         en = i[0]; in_data = 8'($urandom); in_sel = 2'($urandom); in_bcast = i[1];
         #1;
         check("stall_valid", 32'(out_valid), 32'b0010);
         check("stall_data", 32'(out_data), 32'h77);
         check("stall_rdy", 32'(in_ready), 32'h0);
         @(posedge clk); #1;
      end
      en = 1'b1; in_valid = 1'b0; in_bcast = 1'b0; out_ready = 4'hF;
      @(posedge clk); #1;
      check("stall_done", 32'(out_valid), 32'h0);

      // Asynchronous reset mid-broadcast
      in_valid = 1'b1; in_data = 8'h99; in_bcast = 1'b1; out_ready = 4'h0;
      @(posedge clk); #1;
      in_valid = 1'b0; in_bcast = 1'b0;
      check("pre_rst_valid", 32'(out_valid), 32'hF);
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid), 32'h0);
      check("arst_busy", 32'(busy), 32'h0);
      check("arst_cnt", 32'(xfer_cnt), 32'h0);
      check("arst_data", 32'(out_data), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1; in_valid = 1'b1; in_data = 8'h42; in_sel = 2'd1; out_ready = 4'hF;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("post_rst_valid", 32'(out_valid), 32'b0010);
      check("post_rst_data", 32'(out_data), 32'h42);
      @(posedge clk); #1;
      check("post_rst_cnt", 32'(xfer_cnt), 32'h1);

      // Fill the counter to 0xFFFF, then wrap
      nfill = 65535 - int'(mcnt);
      in_valid = 1'b1;
      for (int i = 0; i < nfill; i++) begin
         in_data = 8'(i); in_sel = 2'($urandom); in_bcast = (i % 7 == 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; in_bcast = 1'b0;
      @(posedge clk); #1;
      check("cnt_ffff", 32'(xfer_cnt), 32'hFFFF);
      in_valid = 1'b1; in_data = 8'h5A; in_sel = 2'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("cnt_wrap", 32'(xfer_cnt), 32'h0);
      check("cnt_wrap_idle", 32'(out_valid), 32'h0);

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
